// File: rtl/cavlc_run_scan_pkg.sv
// Shared constants and types for the CAVLC run/level scanner.
// Block-size codes, the trailing-ones cap and the scan FSM state type live here.
package cavlc_run_scan_pkg;

  localparam int unsigned DEF_COEF_W = 12;
  localparam logic [4:0]  MAXC_CDC   = 5'd4;
  localparam logic [4:0]  MAXC_AC    = 5'd15;
  localparam logic [4:0]  MAXC_LUMA  = 5'd16;
  localparam logic [1:0]  T1_CAP     = 2'd3;

  typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} scan_state_e;

  // Any unrecognised size code scans the full 16-entry block.
  function automatic logic [4:0] blk_len(input logic [4:0] maxc);
    unique case (maxc)
      MAXC_CDC: blk_len = MAXC_CDC;
      MAXC_AC:  blk_len = MAXC_AC;
      default:  blk_len = MAXC_LUMA;
    endcase
  endfunction

endpackage

// File: rtl/cavlc_run_scan_if.sv
// Block-in / run-buffer-out bundle of the run scanner.
// master = scanner side, slave = block source plus run-buffer consumer.
interface cavlc_run_scan_if #(
    parameter int unsigned COEF_W = 12,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned RUN_W  = 4
) ();
    logic                     blk_start;
    logic [16*COEF_W-1:0]     blk_coef;
    logic [4:0]               max_coeff;
    logic                     busy;
    logic                     done;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [COEF_W-1:0] wr_level;
    logic [RUN_W-1:0]         wr_run;
    logic [4:0]               total_coeff;
    logic [1:0]               trailing_ones;
    logic [3:0]               total_zeros;

    modport master (
        input  blk_start, blk_coef, max_coeff,
        output busy, done, wr_en, wr_addr, wr_level, wr_run,
        output total_coeff, trailing_ones, total_zeros
    );

    modport slave (
        output blk_start, blk_coef, max_coeff,
        input  busy, done, wr_en, wr_addr, wr_level, wr_run,
        input  total_coeff, trailing_ones, total_zeros
    );
endinterface

// File: rtl/cavlc_coef_sel.sv
// Combinational 16:1 coefficient select with zero and +/-1 classification.
module cavlc_coef_sel #(
    parameter int unsigned COEF_W = 12
) (
    input  logic [16*COEF_W-1:0]     coefs,
    input  logic [3:0]               idx,
    output logic signed [COEF_W-1:0] coef,
    output logic                     is_zero,
    output logic                     is_one
);
    always_comb begin
        coef    = coefs[idx*COEF_W +: COEF_W];
        is_zero = (coef == '0);
        // All-ones is -1; the most negative value is deliberately not a trailing one.
        is_one  = (coef == COEF_W'(1)) || (coef == '1);
    end
endmodule

// File: rtl/cavlc_run_scan.sv
// Scans a zig-zag residual block high-to-low, emitting (level, run_before) entries
// to the run buffer and a TotalCoeff / TrailingOnes / total_zeros summary.
module cavlc_run_scan
    import cavlc_run_scan_pkg::*;
#(
    parameter int unsigned COEF_W = DEF_COEF_W,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned RUN_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    cavlc_run_scan_if.master bus
);
    scan_state_e              state_q, state_d;
    logic [16*COEF_W-1:0]     coef_q, coef_d;
    logic [3:0]               idx_q, idx_d;
    logic                     pend_q, pend_d;
    logic signed [COEF_W-1:0] pend_level_q, pend_level_d;
    logic [RUN_W-1:0]         zcnt_q, zcnt_d;
    logic [4:0]               wcnt_q, wcnt_d;
    logic [1:0]               t1cnt_q, t1cnt_d;
    logic                     t1stop_q, t1stop_d;
    logic [3:0]               tz_q, tz_d;
    logic                     busy_q, busy_d, done_q, done_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
    logic signed [COEF_W-1:0] wr_level_q, wr_level_d;
    logic [RUN_W-1:0]         wr_run_q, wr_run_d;
    logic [4:0]               tc_q, tc_d;
    logic [1:0]               t1_q, t1_d;
    logic [3:0]               tzo_q, tzo_d;

    logic signed [COEF_W-1:0] cur;
    logic                     cur_zero, cur_one, emit;

    cavlc_coef_sel #(.COEF_W(COEF_W)) u_sel (
        .coefs   (coef_q),
        .idx     (idx_q),
        .coef    (cur),
        .is_zero (cur_zero),
        .is_one  (cur_one)
    );

    always_comb begin
        state_d      = state_q;
        coef_d       = coef_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        pend_level_d = pend_level_q;
        zcnt_d       = zcnt_q;
        wcnt_d       = wcnt_q;
        t1cnt_d      = t1cnt_q;
        t1stop_d     = t1stop_q;
        tz_d         = tz_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_level_d   = wr_level_q;
        wr_run_d     = wr_run_q;
        tc_d         = tc_q;
        t1_d         = t1_q;
        tzo_d        = tzo_q;
        emit         = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.blk_start) begin
                    state_d  = StScan;
                    coef_d   = bus.blk_coef;
                    idx_d    = 4'(blk_len(bus.max_coeff) - 5'd1);
                    pend_d   = 1'b0;
                    zcnt_d   = '0;
                    wcnt_d   = '0;
                    t1cnt_d  = '0;
                    t1stop_d = 1'b0;
                    tz_d     = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StScan: begin
                if (cur_zero) begin
                    // Zeros above the highest nonzero coefficient carry no run.
                    if (pend_q) begin
                        zcnt_d = zcnt_q + RUN_W'(1);
                        tz_d   = tz_q + 4'd1;
                    end
                end else begin
                    emit         = pend_q;
                    pend_d       = 1'b1;
                    pend_level_d = cur;
                    zcnt_d       = '0;
                    if (!t1stop_q && cur_one && (t1cnt_q < T1_CAP)) begin
                        t1cnt_d = t1cnt_q + 2'd1;
                    end else begin
                        t1stop_d = 1'b1;
                    end
                end
                if (idx_q == 4'd0) state_d = StFlush;
                else               idx_d   = idx_q - 4'd1;
            end
            StFlush: begin
                emit    = pend_q;
                pend_d  = 1'b0;
                state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        if (emit) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = wcnt_q[ADDR_W-1:0];
            wr_level_d = pend_level_q;
            wr_run_d   = zcnt_q;
            wcnt_d     = wcnt_q + 5'd1;
        end

        // Summary includes the flush write, so it takes the post-emit count.
        if (state_q == StFlush) begin
            tc_d  = wcnt_d;
            t1_d  = t1cnt_d;
            tzo_d = tz_d;
        end

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            coef_q       <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_level_q <= '0;
            zcnt_q       <= '0;
            wcnt_q       <= '0;
            t1cnt_q      <= '0;
            t1stop_q     <= 1'b0;
            tz_q         <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_level_q   <= '0;
            wr_run_q     <= '0;
            tc_q         <= '0;
            t1_q         <= '0;
            tzo_q        <= '0;
        end else begin
            state_q      <= state_d;
            coef_q       <= coef_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_level_q <= pend_level_d;
            zcnt_q       <= zcnt_d;
            wcnt_q       <= wcnt_d;
            t1cnt_q      <= t1cnt_d;
            t1stop_q     <= t1stop_d;
            tz_q         <= tz_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_level_q   <= wr_level_d;
            wr_run_q     <= wr_run_d;
            tc_q         <= tc_d;
            t1_q         <= t1_d;
            tzo_q        <= tzo_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.wr_en         = wr_en_q;
    assign bus.wr_addr       = wr_addr_q;
    assign bus.wr_level      = wr_level_q;
    assign bus.wr_run        = wr_run_q;
    assign bus.total_coeff   = tc_q;
    assign bus.trailing_ones = t1_q;
    assign bus.total_zeros   = tzo_q;
endmodule

// File: tb/tb_cavlc_run_scan.sv
// Scoreboard bench for cavlc_run_scan: directed blocks push expected writes and
// summaries with their cycle numbers; a negedge monitor pops and compares.
module tb_cavlc_run_scan;
    localparam int CW = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cavlc_run_scan_if #(.COEF_W(CW), .ADDR_W(4), .RUN_W(4)) bus ();

    cavlc_run_scan #(.COEF_W(CW), .ADDR_W(4), .RUN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {int addr; int level; int run; int cyc;} wr_t;
    typedef struct {int tc; int t1; int tz; int cyc;} sum_t;

    wr_t  wq[$];
    sum_t sq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   base = 0;
    logic [16*CW-1:0] coefs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe and done pulse must match the head of its queue.
    wr_t  we;
    sum_t se;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_en) begin
                if (wq.size() == 0) chk("unexpected_wr", 1, 0);
                else begin
                    we = wq.pop_front();
                    chk("wr_addr", int'(bus.wr_addr), we.addr);
                    chk("wr_level", int'($signed(bus.wr_level)), we.level);
                    chk("wr_run", int'(bus.wr_run), we.run);
                    chk("wr_cycle", cyc, we.cyc);
                end
            end
            if (bus.done) begin
                if (sq.size() == 0) chk("unexpected_done", 1, 0);
                else begin
                    se = sq.pop_front();
                    chk("total_coeff", int'(bus.total_coeff), se.tc);
                    chk("trailing_ones", int'(bus.trailing_ones), se.t1);
                    chk("total_zeros", int'(bus.total_zeros), se.tz);
                    chk("done_cycle", cyc, se.cyc);
                    chk("busy_at_done", int'(bus.busy), 1);
                end
            end
        end
    end

    task automatic set_c(input int i, input int v);
        coefs[i*CW +: CW] = CW'(v);
    endtask

    task automatic push_wr(input int a, input int l, input int r, input int c);
        wr_t e;
        e = '{addr: a, level: l, run: r, cyc: base + c - 1};
        wq.push_back(e);
    endtask

    task automatic push_sum(input int tc, input int t1, input int tz, input int c);
        sum_t e;
        e = '{tc: tc, t1: t1, tz: tz, cyc: base + c - 1};
        sq.push_back(e);
    endtask

    // Caller sits just after a negedge; the start is sampled at the next posedge.
    task automatic start_blk(input logic [4:0] m);
        bus.blk_coef  = coefs;
        bus.max_coeff = m;
        bus.blk_start = 1'b1;
        @(posedge clk);
        #1 bus.blk_start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #1 n++;
        end while (!bus.done && n < 60);
        if (!bus.done) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 60 cycles");
        end
    endtask

    task automatic chk_reset();
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_wr_en", int'(bus.wr_en), 0);
        chk("rst_wr_addr", int'(bus.wr_addr), 0);
        chk("rst_wr_level", int'(bus.wr_level), 0);
        chk("rst_wr_run", int'(bus.wr_run), 0);
        chk("rst_total_coeff", int'(bus.total_coeff), 0);
        chk("rst_trailing_ones", int'(bus.trailing_ones), 0);
        chk("rst_total_zeros", int'(bus.total_zeros), 0);
    endtask

    task automatic load_t1();
        coefs = '0;
        set_c(1, 3); set_c(2, -1); set_c(5, -1); set_c(6, 1); set_c(8, 1);
    endtask

    task automatic load_cdc();
        coefs = '0;
        set_c(0, 5);
        for (int i = 4; i < 16; i++) set_c(i, 7);
    endtask

    initial begin
        bus.blk_start = 1'b0;
        bus.blk_coef  = '0;
        bus.max_coeff = 5'd16;
        coefs         = '0;
        repeat (2) @(negedge clk);
        #1 chk_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Mixed block, with a spurious start pulsed mid-scan.
        @(negedge clk);
        #1 base = cyc + 1;
        load_t1();
        push_wr(0, 1, 1, 11); push_wr(1, 1, 0, 12); push_wr(2, -1, 2, 15);
        push_wr(3, -1, 0, 16); push_wr(4, 3, 1, 18);
        push_sum(5, 3, 4, 18);
        start_blk(5'd16);
        repeat (3) @(negedge clk);
        #1 bus.blk_coef = '1;
        bus.max_coeff = 5'd4;
        bus.blk_start = 1'b1;
        @(posedge clk);
        #1 bus.blk_start = 1'b0;
        wait_done();

        // All-zero AC block.
        repeat (2) @(negedge clk);
        #1 base = cyc + 1;
        coefs = '0;
        push_sum(0, 0, 0, 17);
        start_blk(5'd15);
        wait_done();

        // All -1, then a chroma DC block started in the DONE cycle.
        @(negedge clk);
        #1 base = cyc + 1;
        for (int i = 0; i < 16; i++) set_c(i, -1);
        for (int k = 0; k < 16; k++) push_wr(k, -1, 0, k + 3);
        push_sum(16, 3, 0, 18);
        start_blk(5'd16);
        wait_done();
        base = cyc + 1;
        load_cdc();
        push_wr(0, 5, 0, 6);
        push_sum(1, 0, 0, 6);
        start_blk(5'd4);
        wait_done();

        // Unknown size code scans 16; most negative level is not a trailing one.
        @(negedge clk);
        #1 base = cyc + 1;
        coefs = '0;
        set_c(15, -2048); set_c(0, 1);
        push_wr(0, -2048, 14, 17); push_wr(1, 1, 0, 18);
        push_sum(2, 0, 14, 18);
        start_blk(5'd7);
        wait_done();

        // Reset during scan cycle 5, then a fresh block.
        @(negedge clk);
        #1 base = cyc + 1;
        load_t1();
        start_blk(5'd16);
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 chk_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        #1 base = cyc + 1;
        load_cdc();
        push_wr(0, 5, 0, 6);
        push_sum(1, 0, 0, 6);
        start_blk(5'd4);
        wait_done();

        repeat (4) @(negedge clk);
        #1 chk("wr_queue_empty", wq.size(), 0);
        chk("sum_queue_empty", sq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
